// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the CPU data-memory responder: FSM states,
// data-segment base address, word width and the address-error decode.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [31:0] DATA_SEG_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  // limit is one past the last valid byte, held in 33 bits so the bound cannot wrap
  function automatic logic addr_err(logic [31:0] addr, logic [31:0] base, logic [32:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response valid-ready bus between the datapath (master) and the
// data-memory responder (slave).
interface data_mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_mem_responder_word_ram.sv
// Single-port word RAM: synchronous write, asynchronous read, no reset
// (contents survive reset).
module word_ram
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wd,
  output logic [WORD_W-1:0]              rd
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
  end

  assign rd = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store word request, fixed
// access latency, error flagging and a saturating error counter.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DATA_SEG_BASE,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [7:0]           err_count
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_t        state, state_nxt;
  logic [3:0]        cnt;
  logic              accept, commit;
  logic              hold_we;
  logic [31:0]       hold_addr;
  logic [WORD_W-1:0] hold_wdata;
  logic              c_we, c_err;
  logic [31:0]       c_addr;
  logic [WORD_W-1:0] c_wdata, ram_rd;
  logic [AW-1:0]     c_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= MEM_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: if (accept) state_nxt = (LATENCY == 1) ? MEM_RESP : MEM_WAIT;
      MEM_WAIT: if (cnt == 4'd0) state_nxt = MEM_RESP;
      MEM_RESP: if (bus.resp_ready) state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Commit happens on the edge entering RESP; with LATENCY==1 that is the
  // accept edge itself, so the live request is used instead of the holding regs.
  always_comb begin
    bus.req_ready  = (state == MEM_IDLE) && !reset;
    bus.resp_valid = (state == MEM_RESP);
    accept         = bus.req_valid && bus.req_ready;
    commit         = !reset && (((state == MEM_IDLE) && accept && (LATENCY == 1)) ||
                                ((state == MEM_WAIT) && (cnt == 4'd0)));
  end

  always_ff @(posedge clk) begin
    if (reset)                              cnt <= '0;
    else if (accept)                        cnt <= CNT_INIT;
    else if (state == MEM_WAIT && cnt != 0) cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_we    <= bus.req_we;
      hold_addr  <= bus.req_addr;
      hold_wdata <= bus.req_wdata;
    end
  end

  always_comb begin
    c_we    = (state == MEM_IDLE) ? bus.req_we    : hold_we;
    c_addr  = (state == MEM_IDLE) ? bus.req_addr  : hold_addr;
    c_wdata = (state == MEM_IDLE) ? bus.req_wdata : hold_wdata;
    c_err   = addr_err(c_addr, BASE_ADDR, LIMIT);
    c_idx   = AW'((c_addr - BASE_ADDR) >> 2);
  end

  word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk (clk),
    .we  (commit && c_we && !c_err),
    .idx (c_idx),
    .wd  (c_wdata),
    .rd  (ram_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else if (commit) begin
      bus.resp_err   <= c_err;
      bus.resp_rdata <= (c_err || c_we) ? '0 : ram_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                      err_count <= '0;
    else if (commit && c_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic checked against an array-based memory model.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = DATA_SEG_BASE;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if bus_a ();
  data_mem_responder_if bus_b ();
  logic [7:0] errc_a, errc_b;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .err_count(errc_a));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .err_count(errc_b));

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  int          ref_errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
    longint unsigned la  = 64'(a);
    longint unsigned lim = 64'(BASE) + 64'(4 * DEPTH);
    return (a % 4 != 0) || (la < 64'(BASE)) || (la >= lim);
  endfunction

  // One complete transaction on the LATENCY=2 instance, resp_ready held high
  task automatic txn_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int k;
    bit err_e, data_chk;
    logic [31:0] exp_rd;
    int unsigned idx;
    k = 0;
    while (bus_a.req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("req_ready_before_req", 32'(bus_a.req_ready), 32'd1);
    bus_a.req_valid = 1'b1; bus_a.req_we = we; bus_a.req_addr = addr; bus_a.req_wdata = wdata;
    @(posedge clk); #1 bus_a.req_valid = 1'b0;
    err_e = model_err(addr);
    exp_rd = 32'd0; data_chk = 1'b1;
    if (err_e) begin
      if (ref_errs < 255) ref_errs++;
    end else begin
      idx = (addr - BASE) / 4;
      if (we) begin ref_mem[idx] = wdata; ref_known[idx] = 1'b1; end
      else begin exp_rd = ref_mem[idx]; data_chk = ref_known[idx]; end
    end
    k = 0;
    do begin @(negedge clk); k++; end while (bus_a.resp_valid !== 1'b1 && k < 20);
    check("latency", 32'(k), 32'(LAT));
    check("resp_err", 32'(bus_a.resp_err), 32'(err_e));
    if (data_chk) check("resp_rdata", bus_a.resp_rdata, exp_rd);
    check("err_count", 32'(errc_a), 32'(ref_errs));
    @(posedge clk); #1;
  endtask

  task automatic txn_b(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input bit exp_err);
    int k;
    k = 0;
    while (bus_b.req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    bus_b.req_valid = 1'b1; bus_b.req_we = we; bus_b.req_addr = addr; bus_b.req_wdata = wdata;
    @(posedge clk); #1 bus_b.req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (bus_b.resp_valid !== 1'b1 && k < 20);
    check("lat1_latency", 32'(k), 32'd1);
    check("lat1_resp_err", 32'(bus_b.resp_err), 32'(exp_err));
    check("lat1_resp_rdata", bus_b.resp_rdata, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, snap_rd;
    int cat;

    reset = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.resp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    check("rst_resp_rdata", bus_a.resp_rdata, 32'd0);
    check("rst_resp_err", 32'(bus_a.resp_err), 32'd0);
    check("rst_err_count", 32'(errc_a), 32'd0);
    check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus_a.req_ready), 32'd1);

    // T1 store then load
    txn_a(1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
    txn_a(1'b0, 32'h1001_0004, 32'h0);

    // T2 misaligned store does not write
    txn_a(1'b1, 32'h1001_0000, 32'hA5A5_0000);
    txn_a(1'b1, 32'h1001_0002, 32'h1234_5678);
    txn_a(1'b0, 32'h1001_0000, 32'h0);

    // T3 range boundaries
    txn_a(1'b1, 32'h1001_0FFC, 32'h0F0F_0FFC);
    txn_a(1'b0, 32'h1001_0FFC, 32'h0);
    txn_a(1'b0, 32'h1001_1000, 32'h0);
    txn_a(1'b0, 32'h1000_FFFC, 32'h0);

    // T4 response back-pressure
    txn_a(1'b1, 32'h1001_000C, 32'h5555_AAAA);
    bus_a.resp_ready = 1'b0;
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 32'h1001_000C;
    @(posedge clk); #1 bus_a.req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    check("bp_resp_valid_rise", 32'(bus_a.resp_valid), 32'd1);
    snap_rd = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1;
        bus_a.req_addr = 32'h1001_000C; bus_a.req_wdata = 32'hBAD0_BAD0;
      end
      if (i == 3) bus_a.req_valid = 1'b0;
      @(negedge clk);
      check("bp_resp_valid", 32'(bus_a.resp_valid), 32'd1);
      check("bp_resp_rdata", bus_a.resp_rdata, snap_rd);
      check("bp_resp_err", 32'(bus_a.resp_err), 32'd0);
      check("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
    end
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_after_hs", 32'(bus_a.req_ready), 32'd1);
    txn_a(1'b0, 32'h1001_000C, 32'h0);

    // T5 reset during WAIT drops the store
    txn_a(1'b1, 32'h1001_0008, 32'h1111_1111);
    bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1;
    bus_a.req_addr = 32'h1001_0008; bus_a.req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1 bus_a.req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ref_errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_mid_resp_valid", 32'(bus_a.resp_valid), 32'd0);
    end
    check("rst_mid_err_count", 32'(errc_a), 32'd0);
    txn_a(1'b0, 32'h1001_0008, 32'h0);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      cat = $urandom_range(0, 9);
      if (cat < 6)       a = BASE + 4 * $urandom_range(0, DEPTH - 1);
      else if (cat == 6) a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      else if (cat == 7) a = BASE - 4 * $urandom_range(1, 64);
      else if (cat == 8) a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 64);
      else               a = $urandom;
      txn_a(1'($urandom_range(0, 1)), a, $urandom);
    end

    // T6 error counter saturation
    for (int i = 0; i < 300; i++) begin
      a = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
      txn_a(1'($urandom_range(0, 1)), a, $urandom);
    end
    check("err_count_saturated", 32'(errc_a), 32'd255);

    // LATENCY=1 instance
    txn_b(1'b1, BASE + 32'h20, 32'h0BAD_CAFE, 32'h0, 1'b0);
    txn_b(1'b0, BASE + 32'h20, 32'h0, 32'h0BAD_CAFE, 1'b0);
    txn_b(1'b0, BASE + 32'h21, 32'h0, 32'h0, 1'b1);
    check("lat1_err_count", 32'(errc_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
